// File: rtl/multicycle_ctrl.sv
// Main control FSM for the multicycle RV32I core: sequences the shared ALU, PC, IR,
// register file and unified memory port for R-type, LW, SW and BEQ.
module multicycle_ctrl #(
  parameter int unsigned RETIRE_W    = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                busy,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_WB_ALU,
    S_MEM_ADDR,
    S_MEM_RD,
    S_WB_MEM,
    S_MEM_WR,
    S_BRANCH,
    S_TRAP
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       busy;
    logic       trap;
  } ctrl_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int unsigned CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_t            state;
  state_t            next_state;
  ctrl_t             ctrl_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic              retire;
  logic              timeout_hit;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    c.busy = (s != S_IDLE) && (s != S_TRAP);
    case (s)
      S_FETCH: begin
        c.mem_req   = 1'b1;
        c.alu_src_b = 2'b01;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b10;
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_WB_ALU: begin
        c.reg_write = 1'b1;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        c.mem_req = 1'b1;
        c.iord    = 1'b1;
      end
      S_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.iord    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
      end
      S_TRAP: begin
        c.trap = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // mem_ready arriving in the same cycle the counter hits its limit wins over the trap
  always_comb begin
    timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_MAX) && !mem_ready;
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    case (state)
      S_IDLE:     if (run) next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready)        next_state = S_DECODE;
        else if (timeout_hit) next_state = S_TRAP;
      end
      S_DECODE: begin
        if (opcode == OP_RTYPE)
          next_state = S_EXEC_R;
        else if (opcode == OP_LOAD || opcode == OP_STORE)
          next_state = S_MEM_ADDR;
        else if (opcode == OP_BRANCH && funct3 == 3'b000)
          next_state = S_BRANCH;
        else
          next_state = S_TRAP;
      end
      S_EXEC_R:   next_state = S_WB_ALU;
      S_MEM_ADDR: next_state = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)        next_state = S_WB_MEM;
        else if (timeout_hit) next_state = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = run ? S_FETCH : S_IDLE;
        end else if (timeout_hit) begin
          next_state = S_TRAP;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        retire     = 1'b1;
        next_state = run ? S_FETCH : S_IDLE;
      end
      S_TRAP:     next_state = S_TRAP;
      default:    next_state = S_IDLE;
    endcase
  end

  // Moore outputs are registered from the next-state decode so they line up with state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ctrl_q   <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state  <= next_state;
      ctrl_q <= decode(next_state);
      if (next_state != state)
        wait_cnt <= '0;
      else if ((MEM_TIMEOUT != 0) && ctrl_q.mem_req && !mem_ready)
        wait_cnt <= wait_cnt + 1'b1;
      if (retire)
        retired <= retired + 1'b1;
    end
  end

  always_comb begin
    mem_req    = ctrl_q.mem_req;
    mem_we     = ctrl_q.mem_we;
    iord       = ctrl_q.iord;
    alu_src_a  = ctrl_q.alu_src_a;
    alu_src_b  = ctrl_q.alu_src_b;
    alu_op     = ctrl_q.alu_op;
    reg_write  = ctrl_q.reg_write;
    mem_to_reg = ctrl_q.mem_to_reg;
    busy       = ctrl_q.busy;
    trap       = ctrl_q.trap;
    ir_write   = (state == S_FETCH) && mem_ready;
    pc_write   = ((state == S_FETCH) && mem_ready) || ((state == S_BRANCH) && zero);
    pc_src     = {1'b0, (state == S_BRANCH) && zero};
  end

endmodule
